// File: rtl/hilotof_cmd_bridge_pkg.sv
// hilotof_pkg: command bytes, reply bytes, FSM state codes and word type for the HiLoTOF bridge
package hilotof_pkg;
  typedef logic [31:0] word_t;
  typedef logic [2:0] state_t;
  localparam logic [7:0] CMD_NOP = 8'h00;
  localparam logic [7:0] CMD_RESET = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PING = 8'h04;
  localparam logic [7:0] PING_REPLY = 8'h5A;
  localparam logic [7:0] ERR_REPLY = 8'hEE;
  localparam state_t ST_RST = 3'd0;
  localparam state_t ST_IDLE = 3'd1;
  localparam state_t ST_WR_BYTES = 3'd2;
  localparam state_t ST_WR_PUSH = 3'd3;
  localparam state_t ST_RD_WAIT = 3'd4;
  localparam state_t ST_RD_SEND = 3'd5;
  localparam state_t ST_TX_ONE = 3'd6;
endpackage

// File: rtl/hilotof_cmd_bridge_if.sv
// hilotof_cmd_bridge_if: UART byte side and DUT word side of the command bridge
interface hilotof_cmd_bridge_if;
  import hilotof_pkg::*;
  logic [7:0] rx_data;
  logic rx_valid;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic dut_reset;
  word_t dut_din;
  logic dut_din_valid;
  word_t dut_dout;
  logic dut_dout_valid;
  logic dut_dout_ready;
  logic overrun;
  modport master(output rx_data, rx_valid, tx_ready, dut_dout, dut_dout_valid,
                 input tx_data, tx_valid, dut_reset, dut_din, dut_din_valid, dut_dout_ready, overrun);
  modport slave(input rx_data, rx_valid, tx_ready, dut_dout, dut_dout_valid,
                output tx_data, tx_valid, dut_reset, dut_din, dut_din_valid, dut_dout_ready, overrun);
endinterface

// File: rtl/hilotof_word_ser.sv
// hilotof_word_ser: sends the low i_last+1 bytes of a word LSB first over a valid/ready byte port
module hilotof_word_ser
  import hilotof_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  word_t      i_word,
  input  logic [1:0] i_last,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_done
);
  word_t r_word;
  logic r_valid;
  logic [1:0] r_cnt;
  logic [1:0] r_last;
  assign o_data = r_word[7:0];
  assign o_valid = r_valid;
  assign o_done = r_valid && i_ready && r_cnt == r_last;
  // shift one byte out per handshake, drop valid after the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= '0;
      r_valid <= 1'b0;
      r_cnt <= 2'd0;
      r_last <= 2'd0;
    end else if (i_start) begin
      r_word <= i_word;
      r_valid <= 1'b1;
      r_cnt <= 2'd0;
      r_last <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid <= r_cnt != r_last;
      r_cnt <= r_cnt + 2'd1;
      r_word <= r_cnt == r_last ? r_word : r_word >> 8;
    end
  end
endmodule

// File: rtl/hilotof_cmd_bridge.sv
// hilotof_cmd_bridge: decodes UART command bytes into DUT words/resets and returns DUT words as bytes
module hilotof_cmd_bridge
  import hilotof_pkg::*;
#(
  parameter int RESET_CYCLES = 16
) (
  input logic clock,
  input logic reset,
  hilotof_cmd_bridge_if.slave io_bus
);
  localparam int CW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
  state_t r_state;
  logic [CW-1:0] r_rst_cnt;
  logic [1:0] r_byte_cnt;
  word_t r_word;
  logic r_dut_reset;
  word_t r_din;
  logic r_din_valid;
  logic r_dout_ready;
  logic r_overrun;
  logic w_known;
  logic w_reply;
  logic w_rd;
  logic w_busy;
  logic w_ser_done;
  assign w_known = io_bus.rx_data inside {CMD_NOP, CMD_RESET, CMD_WRITE, CMD_READ};
  assign w_reply = r_state == ST_IDLE && io_bus.rx_valid && !w_known;
  assign w_rd = r_state == ST_RD_WAIT && io_bus.dut_dout_valid && r_dout_ready;
  assign w_busy = r_state != ST_IDLE && r_state != ST_WR_BYTES;
  assign io_bus.dut_reset = r_dut_reset;
  assign io_bus.dut_din = r_din;
  assign io_bus.dut_din_valid = r_din_valid;
  assign io_bus.dut_dout_ready = r_dout_ready;
  assign io_bus.overrun = r_overrun;
  hilotof_word_ser u_ser (
    .clk    (clock),
    .rst    (reset),
    .i_start(w_reply || w_rd),
    .i_word (w_rd ? io_bus.dut_dout : {24'h0, io_bus.rx_data == CMD_PING ? PING_REPLY : ERR_REPLY}),
    .i_last (w_rd ? 2'd3 : 2'd0),
    .i_ready(io_bus.tx_ready),
    .o_data (io_bus.tx_data),
    .o_valid(io_bus.tx_valid),
    .o_done (w_ser_done)
  );
  // command FSM; bytes arriving outside IDLE/WR_BYTES are dropped and flagged
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_RST;
      r_rst_cnt <= '0;
      r_byte_cnt <= 2'd0;
      r_word <= '0;
      r_dut_reset <= 1'b1;
      r_din <= '0;
      r_din_valid <= 1'b0;
      r_dout_ready <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_din_valid <= 1'b0;
      if (io_bus.rx_valid && w_busy) r_overrun <= 1'b1;
      case (r_state)
        ST_RST: begin
          r_rst_cnt <= r_rst_cnt + 1'b1;
          if (r_rst_cnt == CW'(RESET_CYCLES - 1)) begin
            r_state <= ST_IDLE;
            r_dut_reset <= 1'b0;
          end
        end
        ST_IDLE: if (io_bus.rx_valid) begin
          case (io_bus.rx_data)
            CMD_NOP: r_state <= ST_IDLE;
            CMD_RESET: begin
              r_state <= ST_RST;
              r_rst_cnt <= '0;
              r_dut_reset <= 1'b1;
            end
            CMD_WRITE: begin
              r_state <= ST_WR_BYTES;
              r_byte_cnt <= 2'd0;
            end
            CMD_READ: begin
              r_state <= ST_RD_WAIT;
              r_dout_ready <= 1'b1;
            end
            default: r_state <= ST_TX_ONE;
          endcase
        end
        ST_WR_BYTES: if (io_bus.rx_valid) begin
          r_word[8*r_byte_cnt +: 8] <= io_bus.rx_data;
          r_byte_cnt <= r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            r_state <= ST_WR_PUSH;
            r_din <= {io_bus.rx_data, r_word[23:0]};
            r_din_valid <= 1'b1;
          end
        end
        ST_WR_PUSH: r_state <= ST_IDLE;
        ST_RD_WAIT: if (w_rd) begin
          r_state <= ST_RD_SEND;
          r_dout_ready <= 1'b0;
        end
        ST_RD_SEND, ST_TX_ONE: if (w_ser_done) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hilotof_cmd_bridge.sv
// tb_hilotof_cmd_bridge: directed vector table plus hand sequences for reset, read and overrun cases
module tb_hilotof_cmd_bridge;
  logic clock = 1'b0;
  logic reset = 1'b1;
  bit toggle = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] tx_q[$];
  logic [31:0] din_q[$];
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic prst = 1'b1;
  logic [7:0] pd = 8'h00;
  typedef struct {
    logic [7:0] cmd;
    logic [31:0] arg;
    int exp_tx;
    logic [7:0] exp_byte;
    int exp_din;
  } vec_t;
  vec_t vecs[7];
  hilotof_cmd_bridge_if bus ();
  hilotof_cmd_bridge #(.RESET_CYCLES(16)) dut (.clock(clock), .reset(reset), .io_bus(bus));
  always #5 clock = ~clock;
  always @(posedge clock) begin
    #1;
    bus.tx_ready = toggle ? ~bus.tx_ready : 1'b1;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clock) begin
    if (!reset && !prst && pv && !pr) begin
      chk("tx_hold_valid", {31'd0, bus.tx_valid}, 32'd1);
      chk("tx_hold_data", {24'd0, bus.tx_data}, {24'd0, pd});
    end
    if (!reset && bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
    if (!reset && bus.dut_din_valid) din_q.push_back(bus.dut_din);
    pv = bus.tx_valid;
    pr = bus.tx_ready;
    pd = bus.tx_data;
    prst = reset;
  end
  task automatic send_rx(input logic [7:0] b);
    @(posedge clock);
    #1;
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.rx_valid = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_rx(w[8*i +: 8]);
  endtask
  task automatic do_read(input logic [31:0] w, input int dly);
    int k;
    repeat (dly) @(posedge clock);
    #1;
    bus.dut_dout = w;
    bus.dut_dout_valid = 1'b1;
    k = 0;
    while (k < 30) begin
      @(negedge clock);
      if (bus.dut_dout_ready) break;
      k++;
    end
    chk("dout_ready_seen", {31'd0, bus.dut_dout_ready}, 32'd1);
    @(posedge clock);
    #1;
    bus.dut_dout_valid = 1'b0;
    bus.dut_dout = '0;
    @(negedge clock);
    chk("dout_ready_drop", {31'd0, bus.dut_dout_ready}, 32'd0);
  endtask
  task automatic check_bytes(input string nm, input logic [31:0] w);
    int k;
    k = 0;
    while (tx_q.size() < 4 && k < 60) begin
      @(negedge clock);
      k++;
    end
    repeat (4) @(negedge clock);
    chk({nm, "_count"}, tx_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < tx_q.size()) chk({nm, "_byte"}, {24'd0, tx_q[i]}, {24'd0, w[8*i +: 8]});
    chk({nm, "_txv_low"}, {31'd0, bus.tx_valid}, 32'd0);
  endtask
  task automatic count_dut_reset(input string nm);
    int n;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (bus.dut_reset) n++;
      if (bus.tx_valid) chk({nm, "_txv"}, 32'd1, 32'd0);
    end
    chk({nm, "_len"}, n, 32'd16);
    chk({nm, "_final"}, {31'd0, bus.dut_reset}, 32'd0);
  endtask
  initial begin
    vecs[0] = '{8'h02, 32'h12345678, 0, 8'h00, 1};
    vecs[1] = '{8'h04, 32'h0, 1, 8'h5A, 0};
    vecs[2] = '{8'h7F, 32'h0, 1, 8'hEE, 0};
    vecs[3] = '{8'h00, 32'h0, 0, 8'h00, 0};
    vecs[4] = '{8'h02, 32'hA5C30FF0, 0, 8'h00, 1};
    vecs[5] = '{8'hFF, 32'h0, 1, 8'hEE, 0};
    vecs[6] = '{8'h05, 32'h0, 1, 8'hEE, 0};
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    bus.dut_dout = '0;
    bus.dut_dout_valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_dut_reset", {31'd0, bus.dut_reset}, 32'd1);
    chk("rst_din", bus.dut_din, 32'd0);
    chk("rst_din_valid", {31'd0, bus.dut_din_valid}, 32'd0);
    chk("rst_dout_ready", {31'd0, bus.dut_dout_ready}, 32'd0);
    chk("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    count_dut_reset("rel_dut_reset");
    foreach (vecs[v]) begin
      tx_q.delete();
      din_q.delete();
      send_rx(vecs[v].cmd);
      if (vecs[v].cmd == 8'h02) send_word(vecs[v].arg);
      repeat (6) @(negedge clock);
      chk("vec_tx_count", tx_q.size(), vecs[v].exp_tx);
      if (vecs[v].exp_tx > 0 && tx_q.size() > 0) chk("vec_tx_byte", {24'd0, tx_q[0]}, {24'd0, vecs[v].exp_byte});
      chk("vec_din_count", din_q.size(), vecs[v].exp_din);
      if (vecs[v].exp_din > 0 && din_q.size() > 0) chk("vec_din", din_q[0], vecs[v].arg);
      chk("vec_overrun", {31'd0, bus.overrun}, 32'd0);
    end
    tx_q.delete();
    send_rx(8'h03);
    @(negedge clock);
    chk("rd_ready_up", {31'd0, bus.dut_dout_ready}, 32'd1);
    do_read(32'hDEADBEEF, 10);
    check_bytes("rd", 32'hDEADBEEF);
    toggle = 1'b1;
    tx_q.delete();
    send_rx(8'h03);
    do_read(32'hDEADBEEF, 10);
    check_bytes("rd_tog", 32'hDEADBEEF);
    toggle = 1'b0;
    repeat (2) @(posedge clock);
    send_rx(8'h01);
    count_dut_reset("cmd_dut_reset");
    tx_q.delete();
    send_rx(8'h03);
    send_rx(8'h55);
    @(negedge clock);
    chk("ovr_set", {31'd0, bus.overrun}, 32'd1);
    do_read(32'h01020304, 3);
    check_bytes("ovr_rd", 32'h01020304);
    chk("ovr_sticky", {31'd0, bus.overrun}, 32'd1);
    din_q.delete();
    send_rx(8'h02);
    send_rx(8'h11);
    send_rx(8'h22);
    @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (20) @(negedge clock);
    chk("abort_no_din", din_q.size(), 32'd0);
    chk("abort_overrun_clr", {31'd0, bus.overrun}, 32'd0);
    chk("abort_dut_reset", {31'd0, bus.dut_reset}, 32'd0);
    send_rx(8'h02);
    send_word(32'hDDCCBBAA);
    repeat (4) @(negedge clock);
    chk("post_din_count", din_q.size(), 32'd1);
    if (din_q.size() > 0) chk("post_din", din_q[0], 32'hDDCCBBAA);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hilotof_cmd_bridge.md
Name: hilotof_cmd_bridge

Overview:
Byte-to-word command bridge between the UART byte engines and the DUT 32-bit stream interface inside the HiLoTOF controller. Decodes host command bytes from the UART receiver, assembles little-endian 32-bit words for the DUT input and generates DUT reset pulses. Drains DUT output words and serialises them back to the UART transmitter as bytes.

Parameters:
RESET_CYCLES, 16, cycles dut_reset is held high after reset release or a RESET command (>=1)
CMD_NOP, 8'h00, ignored command
CMD_RESET, 8'h01, pulse dut_reset
CMD_WRITE, 8'h02, next 4 bytes form one din word
CMD_READ, 8'h03, return next dout word as 4 bytes
CMD_PING, 8'h04, reply with PING_REPLY
PING_REPLY, 8'h5A, ping response byte
ERR_REPLY, 8'hEE, reply to an unknown command

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_data  in  8  received byte from the UART RX
rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure
tx_data  out  8  byte to the UART TX
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART TX accepts the byte when tx_valid&&tx_ready
dut_reset  out  1  DUT reset, active-high
dut_din  out  32  assembled input word
dut_din_valid  out  1  one-cycle strobe, dut_din valid
dut_dout  in  32  DUT output word
dut_dout_valid  in  1  DUT output word available
dut_dout_ready  out  1  bridge accepts dut_dout
overrun  out  1  sticky: an rx byte was dropped while busy

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clock, reset).
- Reset values: dut_reset=1, dut_din=0, dut_din_valid=0, dut_dout_ready=0, tx_valid=0, tx_data=0, overrun=0, state=RST, rst_cnt=0.
- All outputs are registered.
- States: RST, IDLE, WR_BYTES, WR_PUSH, RD_WAIT, RD_SEND, TX_ONE.
- RST:
  - dut_reset=1 and rst_cnt increments.
  - When rst_cnt==RESET_CYCLES-1, go to IDLE and clear dut_reset the next cycle.
  - dut_reset is therefore high for exactly RESET_CYCLES cycles after the reset release or the command byte.
- IDLE: on rx_valid, decode rx_data:
  - RESET: go to RST, clear rst_cnt.
  - WRITE: go to WR_BYTES, clear byte_cnt.
  - READ: go to RD_WAIT.
  - PING: go to TX_ONE with tx_data=PING_REPLY.
  - NOP: stay in IDLE.
  - Any other value: go to TX_ONE with tx_data=ERR_REPLY.
- WR_BYTES:
  - Each rx_valid stores rx_data into word byte[byte_cnt], LSB first, and increments the 2-bit byte_cnt.
  - The 4th byte moves to WR_PUSH.
  - No inter-byte timeout.
- WR_PUSH: dut_din=word and dut_din_valid=1 for exactly one cycle, then IDLE. The DUT has no din_ready; the word is presented once.
- RD_WAIT:
  - dut_dout_ready=1.
  - The transfer happens in the cycle where dut_dout_valid&&dut_dout_ready. The bridge latches dut_dout, drops dut_dout_ready the next cycle and goes to RD_SEND.
  - Waits indefinitely; an external reset is the only exit.
- RD_SEND:
  - Sends the latched word as 4 bytes, LSB first.
  - tx_valid stays high and tx_data stays stable until tx_ready; the next byte follows with no idle cycle.
  - After the 4th handshake, go to IDLE with tx_valid=0.
- TX_ONE: holds tx_valid with the single reply byte until tx_ready, then IDLE.
- Overrun:
  - rx_valid in RST, WR_PUSH, RD_WAIT, RD_SEND or TX_ONE drops the byte and sets overrun=1.
  - overrun is cleared only by reset.
- rx_valid in the same cycle as the final tx handshake is dropped (the state is still busy).
- Reset mid-operation:
  - Aborts any transaction and discards partial words and pending tx bytes.
  - tx_valid falls the cycle after reset even if mid-handshake.

Decomposition:
- Package hilotof_pkg:
  - command byte constants (CMD_*), PING_REPLY, ERR_REPLY
  - state enum typedef
  - a 32-bit word typedef
- Sub-module hilotof_word_ser:
  - 32-bit to 4-byte serialiser with valid/ready, used by RD_SEND.
  - Loads a word on start and outputs bytes LSB first.

Test Plan:
- Reset release with RESET_CYCLES=16 -> dut_reset high for 16 cycles after reset falls, then 0; tx_valid=0 throughout.
- rx bytes 02,78,56,34,12 -> one-cycle dut_din_valid with dut_din=32'h12345678; overrun=0.
- rx 03, DUT asserts dut_dout_valid with 32'hDEADBEEF 10 cycles later -> dut_dout_ready accepts it; tx bytes EF,BE,AD,DE. Repeat with tx_ready toggling every other cycle -> same bytes, each held stable until accepted.
- rx 04 -> tx 5A; rx 7F -> tx EE; rx 00 -> no tx activity.
- rx 03, then rx 55 while in RD_WAIT -> byte dropped, overrun=1; a subsequent dout word is still sent correctly.
- rx 02,11,22 then reset -> no dut_din_valid. After the reset sequence, rx 02,AA,BB,CC,DD -> dut_din=32'hDDCCBBAA.
